// File: rtl/noc_rr_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_rr_port_arbiter_if : request/grant bundle for one router output port
// Rev 1.0
// ---------------------------------------------------------------------------
interface noc_rr_port_arbiter_if #(
  parameter int P     = 5,
  parameter int BIN_W = (P > 1) ? $clog2(P) : 1
);
  logic [P-1:0]     req;
  logic [P-1:0]     tail;
  logic             out_ready;
  logic [P-1:0]     grant;
  logic [BIN_W-1:0] grant_bin;
  logic             grant_valid;
  logic             xfer;
  logic             locked;

  modport master (
    output req, tail, out_ready,
    input  grant, grant_bin, grant_valid, xfer, locked
  );

  modport slave (
    input  req, tail, out_ready,
    output grant, grant_bin, grant_valid, xfer, locked
  );
endinterface
`default_nettype wire

// File: rtl/noc_rr_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_rr_port_arbiter : round-robin output-port arbiter, packet locking
// enabled by NOC_ARB_PKT_LOCK_EN (flit-level arbitration otherwise).
// Rev 1.0
// ---------------------------------------------------------------------------
module noc_rr_port_arbiter #(
  parameter int P     = 5,
  parameter int BIN_W = (P > 1) ? $clog2(P) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  noc_rr_port_arbiter_if.slave  bus
);

  localparam logic [P-1:0] C_PRIO_RST = P'(1);

  logic [P-1:0]     r_prio;
  logic [P-1:0]     w_prio_nxt;
  logic [P-1:0]     w_winner;
  logic             w_found;
  logic [P-1:0]     w_grant;
  logic [BIN_W-1:0] w_bin;
  logic             w_xfer;
  logic             w_locked;

  function automatic logic [P-1:0] rotl1(input logic [P-1:0] v);
    return {v[P-2:0], v[P-1]};
  endfunction

  // Scan upward from the priority position, wrapping P-1 -> 0.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int j = 0; j < P; j++) begin
      if (r_prio[j]) begin
        for (int k = 0; k < P; k++) begin
          if (!w_found && bus.req[(j + k) % P]) begin
            w_winner[(j + k) % P] = 1'b1;
            w_found               = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_bin = '0;
    for (int i = 0; i < P; i++) begin
      if (w_grant[i]) w_bin = w_bin | BIN_W'(i);
    end
  end

`ifdef NOC_ARB_PKT_LOCK_EN
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [P-1:0] r_owner;
  logic [P-1:0] w_owner_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_prio  <= C_PRIO_RST;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  // Grant never depends on out_ready; only the state update does.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    w_grant     = (r_state == ST_LOCKED) ? (r_owner & bus.req) : w_winner;
    w_xfer      = (|w_grant) & bus.out_ready;
    if (w_xfer) begin
      case (r_state)
        ST_IDLE: begin
          if (|(w_grant & bus.tail)) begin
            w_prio_nxt = rotl1(w_grant);
          end else begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_grant;
          end
        end
        ST_LOCKED: begin
          if (|(r_owner & bus.tail)) begin
            w_state_nxt = ST_IDLE;
            w_owner_nxt = '0;
            w_prio_nxt  = rotl1(r_owner);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_locked = (r_state == ST_LOCKED);
`else
  logic w_unused_tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prio <= C_PRIO_RST;
    else       r_prio <= w_prio_nxt;
  end

  always_comb begin
    w_grant    = w_winner;
    w_xfer     = (|w_grant) & bus.out_ready;
    w_prio_nxt = w_xfer ? rotl1(w_grant) : r_prio;
  end

  assign w_locked      = 1'b0;
  assign w_unused_tail = ^bus.tail;
`endif

  assign bus.grant       = w_grant;
  assign bus.grant_bin   = w_bin;
  assign bus.grant_valid = |w_grant;
  assign bus.xfer        = w_xfer;
  assign bus.locked      = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_noc_rr_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_noc_rr_port_arbiter : directed vector bench for noc_rr_port_arbiter (P=5)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_noc_rr_port_arbiter;

  localparam int P     = 5;
  localparam int BIN_W = 3;

  typedef struct {
    logic [P-1:0]     req;
    logic [P-1:0]     tail;
    logic             rdy;
    logic [P-1:0]     grant;
    logic [BIN_W-1:0] bin;
    logic             valid;
    logic             xfer;
    logic             locked;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  vec_t vecs[$];

  noc_rr_port_arbiter_if #(.P(P), .BIN_W(BIN_W)) bus ();

  noc_rr_port_arbiter #(.P(P), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [P-1:0] req, input logic [P-1:0] tail, input logic rdy,
                     input logic [P-1:0] grant, input logic [BIN_W-1:0] bin,
                     input logic xfer, input logic locked);
    vec_t v;
    v.req = req; v.tail = tail; v.rdy = rdy; v.grant = grant; v.bin = bin;
    v.valid = |grant; v.xfer = xfer; v.locked = locked;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [P-1:0] grant, input logic [BIN_W-1:0] bin,
                           input logic xfer, input logic locked);
    check({tag, ".grant"},       32'(bus.grant),       32'(grant));
    check({tag, ".grant_bin"},   32'(bus.grant_bin),   32'(bin));
    check({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(|grant));
    check({tag, ".xfer"},        32'(bus.xfer),        32'(xfer));
    check({tag, ".locked"},      32'(bus.locked),      32'(locked));
  endtask

  task automatic drive(input logic [P-1:0] req, input logic [P-1:0] tail, input logic rdy);
    bus.req = req; bus.tail = tail; bus.out_ready = rdy;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    drive('0, '0, 1'b0);

    //   req       tail      rdy  grant     bin   xfer locked
    add(5'b00000, 5'b00000, 1, 5'b00000, 3'd0, 0, 0);
    add(5'b10110, 5'b11111, 1, 5'b00010, 3'd1, 1, 0);
    add(5'b10110, 5'b11111, 1, 5'b00100, 3'd2, 1, 0);
    add(5'b10110, 5'b11111, 1, 5'b10000, 3'd4, 1, 0);
    add(5'b10110, 5'b11111, 0, 5'b00010, 3'd1, 0, 0);
`ifdef NOC_ARB_PKT_LOCK_EN
    // 3-flit packet on input 0
    add(5'b00011, 5'b00000, 1, 5'b00001, 3'd0, 1, 0);
    add(5'b00011, 5'b00000, 1, 5'b00001, 3'd0, 1, 1);
    add(5'b00011, 5'b00001, 1, 5'b00001, 3'd0, 1, 1);
    // lock on input 1, owner drops req while input 3 waits
    add(5'b00011, 5'b00000, 1, 5'b00010, 3'd1, 1, 0);
    add(5'b01000, 5'b00000, 1, 5'b00000, 3'd0, 0, 1);
    add(5'b01000, 5'b00000, 1, 5'b00000, 3'd0, 0, 1);
    add(5'b01010, 5'b00000, 1, 5'b00010, 3'd1, 1, 1);
    add(5'b01010, 5'b00010, 1, 5'b00010, 3'd1, 1, 1);
    // lock on input 2, backpressure for 4 cycles
    add(5'b11111, 5'b00000, 1, 5'b00100, 3'd2, 1, 0);
    for (int i = 0; i < 4; i++) add(5'b11111, 5'b11111, 0, 5'b00100, 3'd2, 0, 1);
    add(5'b11111, 5'b00100, 1, 5'b00100, 3'd2, 1, 1);
    // prio now 01000: wrap through input 4 back to input 0
    add(5'b10001, 5'b11111, 1, 5'b10000, 3'd4, 1, 0);
    add(5'b10001, 5'b11111, 1, 5'b00001, 3'd0, 1, 0);
`else
    // flit-level: tail ignored, rotation on every xfer
    add(5'b00011, 5'b00000, 1, 5'b00001, 3'd0, 1, 0);
    add(5'b00011, 5'b00000, 1, 5'b00010, 3'd1, 1, 0);
    add(5'b00011, 5'b00000, 1, 5'b00001, 3'd0, 1, 0);
    add(5'b10001, 5'b00000, 1, 5'b10000, 3'd4, 1, 0);
    add(5'b10001, 5'b00000, 1, 5'b00001, 3'd0, 1, 0);
    add(5'b11111, 5'b00000, 0, 5'b00010, 3'd1, 0, 0);
    add(5'b11111, 5'b00000, 0, 5'b00010, 3'd1, 0, 0);
`endif
    add(5'b00000, 5'b11111, 1, 5'b00000, 3'd0, 0, 0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].req, vecs[n].tail, vecs[n].rdy);
      @(negedge clk);
      check_all($sformatf("v%0d", n), vecs[n].grant, vecs[n].bin, vecs[n].xfer, vecs[n].locked);
      @(posedge clk);
      #1;
    end

    // Input 3 wins with tail=0: locks (packet mode) or moves prio to 10000 (flit mode)
    drive(5'b01000, 5'b00000, 1'b1);
    @(negedge clk);
    check_all("r0", 5'b01000, 3'd3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
`ifdef NOC_ARB_PKT_LOCK_EN
    check("r1.locked", 32'(bus.locked), 32'd1);
`endif
    // Asynchronous reset mid-cycle
    drive(5'b00000, 5'b00000, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_all("r2", 5'b00000, 3'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    drive(5'b11000, 5'b00000, 1'b0);
    @(negedge clk);
    check_all("r3", 5'b01000, 3'd3, 1'b0, 1'b0);
    drive(5'b01001, 5'b00000, 1'b0);
    #1;
    check_all("r4", 5'b00001, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
